// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the core's data-memory interface. Loads are combinational
//   from ram_read_addr; stores commit on the rising edge. Backs a word RAM at
//   address 0 plus an MMIO page at 0xFFFF_0000:
//     +0x00 CYCLE_LO (RO)  +0x04 CYCLE_HI (RO)
//     +0x08 SECONDS  (RW)  +0x0C CON (write: push byte, read: status)
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ram_read_addr     load byte address (addr[1:0] ignored)
//   ram_write_addr    store byte address (addr[1:0] ignored)
//   ram_write_enable  store strobe
//   ram_data_out      store data from the core
//   ram_data_in       load data to the core
//   con_valid/con_data/con_ready  console FIFO drain handshake
//   tick              one-cycle pulse on every SECONDS increment
//   addr_fault        (ADDR_CHECK_EN only) sticky unmapped/RO-store flag
//
// Optional feature macro: ADDR_CHECK_EN
module data_mem_responder #(
  parameter int ADDR_W     = 12,
  parameter int TICK_DIV   = 1000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ram_read_addr,
  input  logic [31:0] ram_write_addr,
  input  logic        ram_write_enable,
  input  logic [31:0] ram_data_out,
  output logic [31:0] ram_data_in,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        tick
`ifdef ADDR_CHECK_EN
  ,
  output logic        addr_fault
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [27:0] MMIO_PAGE = 28'hFFFF000;

  logic [31:0]   ram_q [2**ADDR_W];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [63:0]   cycle_q;
  logic [CW-1:0] presc_q, presc_d;
  logic [31:0]   seconds_q, seconds_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [15:0]   drop_q;

  // Address decode (full 32-bit compare, byte offset bits ignored)
  logic rd_in_ram, rd_in_mmio, wr_in_ram, wr_in_mmio;
  logic ram_wr, sec_wr, con_push;
  assign rd_in_ram  = (ram_read_addr[31:ADDR_W+2] == '0);
  assign rd_in_mmio = (ram_read_addr[31:4] == MMIO_PAGE);
  assign wr_in_ram  = (ram_write_addr[31:ADDR_W+2] == '0);
  assign wr_in_mmio = (ram_write_addr[31:4] == MMIO_PAGE);
  // Stores are ignored while reset is asserted.
  assign ram_wr   = rst_n && ram_write_enable && wr_in_ram;
  assign sec_wr   = rst_n && ram_write_enable && wr_in_mmio && (ram_write_addr[3:2] == 2'd2);
  assign con_push = rst_n && ram_write_enable && wr_in_mmio && (ram_write_addr[3:2] == 2'd3);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_read_addr[1:0], ram_write_addr[1:0]};

  // FIFO handshake
  logic full, pop, push_ok, drop;
  assign con_valid = (count_q != '0);
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop       = con_valid && con_ready;
  // A full FIFO still accepts when a pop frees a slot in the same cycle.
  assign push_ok   = con_push && (!full || pop);
  assign drop      = con_push && full && !pop;
  assign con_data  = con_valid ? fifo_q[rd_ptr_q] : 8'h00;

  // Prescaler / seconds; a SECONDS store overrides the rollover.
  logic presc_last;
  assign presc_last = (presc_q == CW'(TICK_DIV - 1));
  assign tick       = rst_n && presc_last && !sec_wr;

  always_comb begin
    presc_d   = presc_q + 1'b1;
    seconds_d = seconds_q;
    if (sec_wr) begin
      presc_d   = '0;
      seconds_d = ram_data_out;
    end else if (presc_last) begin
      presc_d   = '0;
      seconds_d = seconds_q + 32'd1;
    end
  end

  // Load data mux; reads see pre-edge state, so a same-cycle store is not visible.
  always_comb begin
    ram_data_in = 32'h0;
    if (rd_in_ram) begin
      ram_data_in = ram_q[ram_read_addr[ADDR_W+1:2]];
    end else if (rd_in_mmio) begin
      case (ram_read_addr[3:2])
        2'd0:    ram_data_in = cycle_q[31:0];
        2'd1:    ram_data_in = cycle_q[63:32];
        2'd2:    ram_data_in = seconds_q;
        default: ram_data_in = {drop_q, 8'(count_q), 6'b0, full, ~con_valid};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      presc_q   <= '0;
      seconds_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= '0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Storage arrays are not reset.
  always_ff @(posedge clk) begin
    if (ram_wr)  ram_q[ram_write_addr[ADDR_W+1:2]] <= ram_data_out;
    if (push_ok) fifo_q[wr_ptr_q] <= ram_data_out[7:0];
  end

`ifdef ADDR_CHECK_EN
  logic fault_q, rd_bad, wr_bad;
  assign rd_bad = !rd_in_ram && !rd_in_mmio;
  // Unmapped store, or store to CYCLE_LO/CYCLE_HI.
  assign wr_bad = ram_write_enable &&
                  ((!wr_in_ram && !wr_in_mmio) || (wr_in_mmio && !ram_write_addr[3]));
  assign addr_fault = fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (rd_bad || wr_bad) begin
      fault_q <= 1'b1;
`ifndef SYNTHESIS
      if (rd_bad) $display("addr_fault: read  addr 0x%08h at cycle %0d", ram_read_addr, cycle_q);
      if (wr_bad) $display("addr_fault: store addr 0x%08h at cycle %0d", ram_write_addr, cycle_q);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (ADDR_W=8, TICK_DIV=4, FIFO_DEPTH=8).
module tb_data_mem_responder;

  localparam logic [31:0] A_LO  = 32'hFFFF_0000;
  localparam logic [31:0] A_HI  = 32'hFFFF_0004;
  localparam logic [31:0] A_SEC = 32'hFFFF_0008;
  localparam logic [31:0] A_CON = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ram_read_addr, ram_write_addr, ram_data_out, ram_data_in;
  logic        ram_write_enable;
  logic        con_valid, con_ready, tick;
  logic [7:0]  con_data;
`ifdef ADDR_CHECK_EN
  logic        addr_fault;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .TICK_DIV(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
    .ram_data_in(ram_data_in),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .tick(tick)
`ifdef ADDR_CHECK_EN
    , .addr_fault(addr_fault)
`endif
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    ram_write_enable = 1'b1;
    ram_write_addr   = a;
    ram_data_out     = d;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] drain2 [8];

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_0004, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 32'h0000_0000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 32'h1111_1111};
    vecs[3]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0010, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0013, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 32'hA5A5_A5A5};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0004, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,         32'h0,         32'h0000_03FF, 1'b1, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0000_0400, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 32'hA5A5_A5A5};
    vecs[10] = '{1'b1, A_HI,          32'hFFFF_FFFF, 32'hFFFF_0010, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0,         32'h0,         A_HI,          1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h0,         32'h0,         32'hFFFE_000C, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'h0,         32'h0,         A_CON,         1'b1, 32'h0000_0001};
    vecs[14] = '{1'b1, 32'h0000_0016, 32'h0BAD_F00D, 32'h0000_0004, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0,         32'h0,         32'h0000_0014, 1'b1, 32'h0BAD_F00D};
    vecs[16] = '{1'b1, 32'h8000_0010, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h0,         32'h0,         32'h0000_0010, 1'b1, 32'hDEAD_BEEF};

    rst_n = 1'b0; ram_write_enable = 1'b0; ram_write_addr = '0; ram_data_out = '0;
    ram_read_addr = A_SEC; con_ready = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_con_valid", {31'b0, con_valid}, 32'h0);
    chk("rst_con_data",  {24'b0, con_data},  32'h0);
    chk("rst_tick",      {31'b0, tick},      32'h0);
    chk("rst_seconds",   ram_data_in,        32'h0);
    step();
    ram_read_addr = A_CON;
    @(negedge clk);
    chk("rst_con_status", ram_data_in, 32'h0000_0001);

    // ---- cycle counter after release ----
    step();
    rst_n = 1'b1;
    ram_read_addr = A_LO;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cycle_lo_after_5", ram_data_in, 32'd5);
    step();

    // ---- RAM / decode vectors ----
    for (int i = 0; i < NV; i++) begin
      ram_write_enable = vecs[i].we;
      ram_write_addr   = vecs[i].waddr;
      ram_data_out     = vecs[i].wdata;
      ram_read_addr    = vecs[i].raddr;
      @(negedge clk);
      if (vecs[i].chk) chk($sformatf("vec%0d_rdata", i), ram_data_in, vecs[i].exp);
      step();
    end
    ram_write_enable = 1'b0;

    // ---- CYCLE_LO wrap carries into CYCLE_HI ----
    force dut.cycle_q = 64'h0000_0003_FFFF_FFFF;
    ram_read_addr = A_LO;
    @(negedge clk);
    chk("cycle_lo_forced", ram_data_in, 32'hFFFF_FFFF);
    release dut.cycle_q;
    step();
    ram_read_addr = A_HI;
    @(negedge clk);
    chk("cycle_hi_wrap", ram_data_in, 32'h0000_0004);
    step();
    ram_read_addr = A_LO;
    @(negedge clk);
    chk("cycle_lo_wrap", ram_data_in, 32'h0000_0001);
    step();

    // ---- SECONDS / tick ----
    store(A_SEC, 32'd41);
    ram_read_addr = A_SEC;
    @(negedge clk);
    chk("tick_in_write_cycle", {31'b0, tick}, 32'h0);
    step();
    ram_write_enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("tick_k%0d", k), {31'b0, tick}, {31'b0, (k == 4)});
      if (k == 4) chk("seconds_before_tick", ram_data_in, 32'd41);
      if (k == 5) chk("seconds_after_tick",  ram_data_in, 32'd42);
      step();
    end
    store(A_SEC, 32'd100);       // prescaler is at 3 in this cycle
    @(negedge clk);
    chk("tick_write_wins", {31'b0, tick}, 32'h0);
    step();
    ram_write_enable = 1'b0;
    @(negedge clk);
    chk("seconds_write_wins", ram_data_in, 32'd100);
    chk("tick_after_write",   {31'b0, tick}, 32'h0);
    step();

    // ---- FIFO fill with overflow ----
    con_ready = 1'b0;
    ram_read_addr = A_CON;
    for (int i = 0; i < 10; i++) begin
      store(A_CON, 32'(i));
      if (i == 0) begin
        @(negedge clk);
        chk("no_bypass_valid", {31'b0, con_valid}, 32'h0);
      end
      step();
    end
    ram_write_enable = 1'b0;
    @(negedge clk);
    chk("fifo_full_status", ram_data_in, 32'h0002_0802);
    chk("fifo_full_valid",  {31'b0, con_valid}, 32'h1);
    chk("fifo_head",        {24'b0, con_data},  32'h0);
    step();
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("drain_valid%0d", i), {31'b0, con_valid}, 32'h1);
      chk($sformatf("drain_data%0d", i),  {24'b0, con_data},  32'(i));
      step();
    end
    @(negedge clk);
    chk("drain_empty_valid", {31'b0, con_valid}, 32'h0);
    step();

    // ---- push into full FIFO with simultaneous pop ----
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      store(A_CON, 32'h10 + 32'(i));
      step();
    end
    store(A_CON, 32'h55);
    con_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_head", {24'b0, con_data}, 32'h10);
    step();
    ram_write_enable = 1'b0;
    con_ready = 1'b0;
    @(negedge clk);
    chk("full_pop_status", ram_data_in, 32'h0002_0802);
    step();
    drain2 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("drain2_data%0d", i), {24'b0, con_data}, {24'b0, drain2[i]});
      step();
    end
    @(negedge clk);
    chk("drain2_empty_valid", {31'b0, con_valid}, 32'h0);
    step();
    con_ready = 1'b0;

    // ---- mid-run reset ----
    for (int i = 0; i < 3; i++) begin
      store(A_CON, 32'hAA + 32'(i));
      step();
    end
    store(A_SEC, 32'd7);
    step();
    ram_write_enable = 1'b0;
    ram_read_addr = A_SEC;
    @(negedge clk);
    chk("seconds_pre_reset", ram_data_in, 32'd7);
    chk("valid_pre_reset",   {31'b0, con_valid}, 32'h1);
    step();
    rst_n = 1'b0;
    store(32'h0000_0010, 32'hBAD0_BAD0);
    step();
    rst_n = 1'b1;
    ram_write_enable = 1'b0;
    @(negedge clk);
    chk("post_reset_valid",   {31'b0, con_valid}, 32'h0);
    chk("post_reset_data",    {24'b0, con_data},  32'h0);
    chk("post_reset_seconds", ram_data_in,        32'h0);
    step();
    ram_read_addr = 32'h0000_0010;
    @(negedge clk);
    chk("ram_kept_over_reset", ram_data_in, 32'hDEAD_BEEF);
    step();
    ram_read_addr = A_CON;
    @(negedge clk);
    chk("post_reset_status", ram_data_in, 32'h0000_0001);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
